// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared constants for the UART transmit arbiter
package uart_tx_arbiter_pkg;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    // Stall-timeout and idle-gap counter width
    localparam int CNT_W = 16;

    // Encoded grant index width (covers up to 16 requesters)
    localparam int IDX_W = 4;

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_select.sv
// rtl/uart_tx_arbiter_rr_priority_select.sv - combinational round-robin pick starting after the last grant
module rr_priority_select
    import uart_tx_arbiter_pkg::*;
#(
    parameter int PORTS = 4
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [PORTS-1:0] sel,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the farthest candidate down to last+1 so the nearest requester wins
    always_comb begin
        int pos;
        sel   = '0;
        idx   = last;
        valid = 1'b0;
        pos   = 0;
        for (int k = PORTS; k >= 1; k--) begin
            pos = (int'(last) + k) % PORTS;
            if (req[pos]) begin
                sel      = '0;
                sel[pos] = 1'b1;
                idx      = IDX_W'(pos);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-locking round-robin arbiter in front of a shared uart_tx
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] input_axi_tdata,
    input  logic [PORTS-1:0]            input_axi_tvalid,
    input  logic [PORTS-1:0]            input_axi_tlast,
    output logic [PORTS-1:0]            input_axi_tready,
    output logic [DATA_WIDTH-1:0]       output_axi_tdata,
    output logic                        output_axi_tvalid,
    input  logic                        output_axi_tready,
    input  logic                        uart_busy,
    output logic [PORTS-1:0]            grant,
    output logic [IDX_W-1:0]            grant_encoded,
    output logic                        timeout_event
);

    logic [1:0]            state;
    logic [CNT_W-1:0]      timeout_cnt;
    logic [CNT_W-1:0]      gap_cnt;
    logic                  drain_ok;

    logic [PORTS-1:0]      pick_sel;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;

    logic                  tready_en;
    logic                  accept;
    logic                  g_valid;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  timeout_hit;
    logic                  drain_idle;

    // grant_encoded doubles as the rotating "last" pointer
    rr_priority_select #(
        .PORTS(PORTS)
    ) u_select (
        .req  (input_axi_tvalid),
        .last (grant_encoded),
        .sel  (pick_sel),
        .idx  (pick_idx),
        .valid(pick_valid)
    );

    assign tready_en        = (state == ST_GRANT) && (!output_axi_tvalid || output_axi_tready);
    assign input_axi_tready = tready_en ? grant : '0;
    assign accept           = |(input_axi_tvalid & input_axi_tready);
    assign g_valid          = |(input_axi_tvalid & grant);
    assign g_last           = |(input_axi_tlast & grant);
    assign drain_idle       = !output_axi_tvalid && !uart_busy;

    // Stall of the granted port: fires on the clock whose increment would reach TIMEOUT
    assign timeout_hit = (TIMEOUT != 0) && (state == ST_GRANT) && !g_valid &&
                         ((timeout_cnt + 16'd1) == CNT_W'(TIMEOUT));

    // Mux the granted port's byte onto the output register input
    always_comb begin
        g_data = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant[i]) begin
                g_data = input_axi_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // One-entry output register feeding the serializer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_axi_tdata  <= '0;
            output_axi_tvalid <= 1'b0;
        end else if (accept) begin
            output_axi_tdata  <= g_data;
            output_axi_tvalid <= 1'b1;
        end else if (output_axi_tready) begin
            output_axi_tvalid <= 1'b0;
        end
    end

    // Arbitration FSM: grant, hold for the frame, drain the serializer, optional idle gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            grant         <= '0;
            grant_encoded <= IDX_W'(PORTS - 1);
            timeout_cnt   <= '0;
            gap_cnt       <= '0;
            drain_ok      <= 1'b0;
            timeout_event <= 1'b0;
        end else begin
            timeout_event <= 1'b0;
            case (state)
                ST_IDLE: begin
                    timeout_cnt <= '0;
                    if (pick_valid) begin
                        grant         <= pick_sel;
                        grant_encoded <= pick_idx;
                        state         <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (accept && g_last) begin
                        grant    <= '0;
                        drain_ok <= 1'b0;
                        state    <= ST_DRAIN;
                    end else if (timeout_hit) begin
                        grant         <= '0;
                        timeout_event <= 1'b1;
                        drain_ok      <= 1'b0;
                        state         <= ST_DRAIN;
                    end else if (accept) begin
                        timeout_cnt <= '0;
                    end else if (!g_valid) begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    // Two idle cycles in a row rule out the serializer's accept-to-busy lag
                    if (drain_idle && drain_ok) begin
                        drain_ok <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= CNT_W'(GAP_CYCLES);
                            state   <= ST_GAP;
                        end
                    end else begin
                        drain_ok <= drain_idle;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt <= 16'd1) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int PORTS = 4;
    localparam int DW    = 8;
    localparam int GAP   = 100;
    localparam int TOUT  = 20;
    localparam int FRAME = 10;

    logic              clk;
    logic              rst;
    logic [PORTS*DW-1:0] in_tdata;
    logic [PORTS-1:0]  in_tvalid;
    logic [PORTS-1:0]  in_tlast;
    logic [PORTS-1:0]  in_tready;
    logic [DW-1:0]     out_tdata;
    logic              out_tvalid;
    logic              ser_ready;
    logic              ser_busy;
    logic [PORTS-1:0]  grant;
    logic [3:0]        grant_encoded;
    logic              timeout_event;

    int checks   = 0;
    int failures = 0;

    logic [7:0] src_data [PORTS][16];
    logic       src_last [PORTS][16];
    int         wr_cnt   [PORTS];
    int         rd_ptr   [PORTS];

    int         ser_cnt;
    logic       ser_lag;
    logic [7:0] ser_log [$];
    logic [3:0] gseq [$];
    logic [3:0] prev_grant;

    uart_tx_arbiter #(
        .PORTS(PORTS), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .input_axi_tdata(in_tdata), .input_axi_tvalid(in_tvalid),
        .input_axi_tlast(in_tlast), .input_axi_tready(in_tready),
        .output_axi_tdata(out_tdata), .output_axi_tvalid(out_tvalid),
        .output_axi_tready(ser_ready), .uart_busy(ser_busy),
        .grant(grant), .grant_encoded(grant_encoded), .timeout_event(timeout_event)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte sources: present queued beats, advance on handshake
    always_comb begin
        in_tvalid = '0;
        in_tlast  = '0;
        in_tdata  = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (rd_ptr[i] < wr_cnt[i]) begin
                in_tvalid[i]        = 1'b1;
                in_tlast[i]         = src_last[i][rd_ptr[i]];
                in_tdata[i*DW +: DW] = src_data[i][rd_ptr[i]];
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PORTS; i++) rd_ptr[i] <= 0;
        end else begin
            for (int i = 0; i < PORTS; i++)
                if (in_tvalid[i] && in_tready[i]) rd_ptr[i] <= rd_ptr[i] + 1;
        end
    end

    // Serializer model: accept, one lag cycle, then busy for FRAME clocks
    assign ser_busy  = (ser_cnt != 0);
    assign ser_ready = (ser_cnt == 0) && !ser_lag;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_cnt <= 0;
            ser_lag <= 1'b0;
        end else if (out_tvalid && ser_ready) begin
            ser_log.push_back(out_tdata);
            ser_lag <= 1'b1;
        end else if (ser_lag) begin
            ser_lag <= 1'b0;
            ser_cnt <= FRAME;
        end else if (ser_cnt != 0) begin
            ser_cnt <= ser_cnt - 1;
        end
    end

    // Record the index of each new grant
    always @(negedge clk) begin
        if (grant != 0 && prev_grant == 0) gseq.push_back(grant_encoded);
        prev_grant = grant;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input logic [7:0] d, input logic l);
        src_data[p][wr_cnt[p]] = d;
        src_last[p][wr_cnt[p]] = l;
        wr_cnt[p]++;
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int c = 0;
        while (ser_log.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(tag, ser_log.size() >= n, 1);
    endtask

    task automatic wait_grant(input int p, input int budget, input string tag);
        int c = 0;
        while (!grant[p] && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(tag, grant[p], 1);
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] e[$]);
        logic [7:0] v;
        chk({tag, "_count"}, ser_log.size(), e.size());
        foreach (e[i]) begin
            v = (i < ser_log.size()) ? ser_log[i] : 8'h00;
            chk($sformatf("%s_byte%0d", tag, i), v, e[i]);
        end
    endtask

    task automatic chk_gseq(input string tag, input logic [3:0] e[$]);
        logic [3:0] v;
        chk({tag, "_count"}, gseq.size(), e.size());
        foreach (e[i]) begin
            v = (i < gseq.size()) ? gseq[i] : 4'hf;
            chk($sformatf("%s_grant%0d", tag, i), v, e[i]);
        end
    endtask

    task automatic clear_logs();
        ser_log.delete();
        gseq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < PORTS; i++) wr_cnt[i] = 0;
        repeat (2) @(negedge clk);
        clear_logs();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] eb [$];
        logic [3:0] eg [$];
        int  c;
        int  n;
        logic pb;
        logic found;

        prev_grant = '0;
        rst = 1'b1;
        for (int i = 0; i < PORTS; i++) wr_cnt[i] = 0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_tready", in_tready, 4'b0000);
        chk("rst_tvalid", out_tvalid, 0);
        chk("rst_tdata", out_tdata, 8'h00);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_grant_encoded", grant_encoded, 4'd3);
        chk("rst_timeout_event", timeout_event, 0);
        rst = 1'b0;

        // Single port: port 2 sends 11 22 33
        @(negedge clk);
        push(2, 8'h11, 0); push(2, 8'h22, 0); push(2, 8'h33, 1);
        @(negedge clk);
        chk("single_grant", grant, 4'b0100);
        chk("single_grant_encoded", grant_encoded, 4'd2);
        chk("single_tready_same_cycle", in_tready, 4'b0100);
        @(negedge clk);
        chk("single_out_valid", out_tvalid, 1);
        chk("single_out_data", out_tdata, 8'h11);
        c = 0;
        while (!(in_tvalid[2] && in_tready[2] && in_tlast[2]) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("single_tlast_seen", in_tvalid[2] && in_tready[2] && in_tlast[2], 1);
        @(negedge clk);
        chk("single_grant_cleared", grant, 4'b0000);
        chk("single_tready_cleared", in_tready, 4'b0000);
        wait_log(3, 300, "single_wait_bytes");
        repeat (150) @(negedge clk);
        eb = '{8'h11, 8'h22, 8'h33};
        chk_bytes("single", eb);

        // Contention after reset: ports 0, 1, 3 -> order 0, 1, 3
        do_reset();
        push(0, 8'hA0, 0); push(0, 8'hA1, 1);
        push(1, 8'hB0, 0); push(1, 8'hB1, 1);
        push(3, 8'hD0, 0); push(3, 8'hD1, 1);
        wait_log(6, 1000, "contend_wait_bytes");
        repeat (150) @(negedge clk);
        eb = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hD0, 8'hD1};
        chk_bytes("contend", eb);
        eg = '{4'd0, 4'd1, 4'd3};
        chk_gseq("contend", eg);

        // Fairness: port 0 back-to-back frames, port 1 cuts in after the first
        clear_logs();
        push(0, 8'h01, 0); push(0, 8'h02, 1);
        push(0, 8'h03, 0); push(0, 8'h04, 1);
        push(0, 8'h05, 0); push(0, 8'h06, 1);
        wait_grant(0, 50, "fair_wait_grant0");
        push(1, 8'h10, 0); push(1, 8'h11, 1);
        wait_log(8, 2000, "fair_wait_bytes");
        repeat (150) @(negedge clk);
        eb = '{8'h01, 8'h02, 8'h10, 8'h11, 8'h03, 8'h04, 8'h05, 8'h06};
        chk_bytes("fair", eb);
        eg = '{4'd0, 4'd1, 4'd0, 4'd0};
        chk_gseq("fair", eg);

        // Timeout: port 1 sends A5 with no tlast, port 2 and port 3 wait
        clear_logs();
        push(1, 8'hA5, 0);
        wait_grant(1, 50, "tout_wait_grant1");
        push(2, 8'hC1, 0); push(2, 8'hC2, 1);
        push(3, 8'hF0, 0); push(3, 8'hF1, 0); push(3, 8'hF2, 0); push(3, 8'hF3, 1);
        c = 0;
        while (!(in_tvalid[1] && in_tready[1]) && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("tout_a5_offered", in_tvalid[1] && in_tready[1], 1);
        @(posedge clk);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (timeout_event) break;
        end
        chk("tout_stall_cycles", n, TOUT);
        chk("tout_grant_revoked", grant, 4'b0000);
        @(posedge clk);
        #1;
        chk("tout_pulse_one_cycle", timeout_event, 0);
        @(negedge clk);
        wait_log(3, 600, "tout_wait_bytes");
        eb = '{8'hA5, 8'hC1, 8'hC2};
        chk_bytes("tout", eb);
        eg = '{4'd1, 4'd2};
        chk_gseq("tout", eg);

        // Gap: busy falls -> 2 drain cycles + GAP gap cycles + 1 idle cycle -> grant
        pb = ser_busy;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (pb && !ser_busy && !out_tvalid) begin
                found = 1'b1;
                break;
            end
            pb = ser_busy;
        end
        chk("gap_busy_fall_seen", found, 1);
        n = 0;
        while (grant == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("gap_idle_clocks", n, GAP + 3);
        chk("gap_next_grant", grant_encoded, 4'd3);

        // Reset mid-frame while port 3 is streaming
        c = 0;
        while (rd_ptr[3] < 2 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("midrst_frame_started", rd_ptr[3] >= 2, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_grant", grant, 4'b0000);
        chk("midrst_tready", in_tready, 4'b0000);
        chk("midrst_out_valid", out_tvalid, 0);
        chk("midrst_out_data", out_tdata, 8'h00);
        chk("midrst_grant_encoded", grant_encoded, 4'd3);
        for (int i = 0; i < PORTS; i++) wr_cnt[i] = 0;
        repeat (2) @(negedge clk);
        clear_logs();
        rst = 1'b0;
        push(2, 8'h73, 1);
        push(1, 8'h72, 1);
        push(0, 8'h71, 1);
        wait_log(3, 1000, "midrst_wait_bytes");
        eb = '{8'h71, 8'h72, 8'h73};
        chk_bytes("midrst", eb);
        chk("midrst_first_grant", (gseq.size() > 0) ? gseq[0] : 4'hf, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
